score_sequencer: RTL and testbench

SCORE_SEQUENCER -- requirements
Module: score_sequencer

---
 rtl/score_pkg.sv | 17 +
 rtl/edge_rise.sv | 26 ++
 rtl/score_sequencer.sv | 118 +++++++++++
 tb/tb_score_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and defaults for the score sequencer: FSM state encoding,
// the score ceiling and the default game parameters.
package score_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PLAY,
        HOLD,
        WIN
    } state_t;

    localparam logic [3:0] SCORE_MAX       = 4'd15;
    localparam logic [3:0] WIN_SCORE_DEF   = 4'd15;
    localparam int         HOLD_CYCLES_DEF = 8;

endpackage

// File: rtl/edge_rise.sv
// Single rising-edge detector: flags a cycle where din is high but was low
// on the previous clock edge. RST_VAL seeds the history register.
module edge_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= RST_VAL;
        end else begin
            prev <= din;
        end
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/score_sequencer.sv
// Game sequencer driving an external 4-bit score counter through one-cycle
// Inc/Dec/LD pulses, with a lockout window after every accepted hit or miss.
module score_sequencer
    import score_pkg::*;
#(
    parameter logic [3:0] WIN_SCORE   = WIN_SCORE_DEF,
    parameter int         HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic [3:0] score,
    output logic       Inc,
    output logic       Dec,
    output logic       LD,
    output logic       playing,
    output logic       won
);

    localparam logic [7:0] HOLD_LEN = 8'(HOLD_CYCLES);

    logic       start_ev;
    logic       hit_ev;
    logic       miss_ev;
    state_t     state;
    logic [7:0] hold_cnt;

    // History resets high so a level already asserted at reset release is
    // not mistaken for a fresh press.
    edge_rise #(.RST_VAL(1'b1)) u_start_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (start),
        .rise (start_ev)
    );

    edge_rise #(.RST_VAL(1'b1)) u_hit_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (hit),
        .rise (hit_ev)
    );

    edge_rise #(.RST_VAL(1'b1)) u_miss_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (miss),
        .rise (miss_ev)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
            Inc      <= 1'b0;
            Dec      <= 1'b0;
            LD       <= 1'b0;
            playing  <= 1'b0;
            won      <= 1'b0;
        end else begin
            // Pulses default low so each accepted event yields exactly one cycle.
            Inc <= 1'b0;
            Dec <= 1'b0;
            LD  <= 1'b0;

            if (start_ev) begin
                state    <= CLEAR;
                hold_cnt <= 8'd0;
                LD       <= 1'b1;
                playing  <= 1'b0;
                won      <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    CLEAR: begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end
                    PLAY: begin
                        if (hit_ev && !miss_ev && score < SCORE_MAX) begin
                            Inc      <= 1'b1;
                            state    <= HOLD;
                            hold_cnt <= HOLD_LEN;
                        end else if (miss_ev && !hit_ev && score != 4'd0) begin
                            Dec      <= 1'b1;
                            state    <= HOLD;
                            hold_cnt <= HOLD_LEN;
                        end
                    end
                    HOLD: begin
                        // The final HOLD cycle judges the already-updated score.
                        if (hold_cnt <= 8'd1) begin
                            hold_cnt <= 8'd0;
                            if (score >= WIN_SCORE) begin
                                state   <= WIN;
                                playing <= 1'b0;
                                won     <= 1'b1;
                            end else begin
                                state <= PLAY;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                    WIN: ;
                    default: begin
                        state   <= IDLE;
                        playing <= 1'b0;
                        won     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_sequencer.sv
// Self-checking bench for score_sequencer: directed scenarios followed by
// random play, compared against a behavioural game model and score counter.
module tb_score_sequencer;

    localparam int         HOLD_CYCLES = 8;
    localparam logic [3:0] WIN_SCORE   = 4'd15;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       hit;
    logic       miss;
    logic [3:0] score;
    logic       Inc;
    logic       Dec;
    logic       LD;
    logic       playing;
    logic       won;

    logic       preset_en;
    logic [3:0] preset_val;

    int n_pass;
    int n_total;

    // Behavioural game model
    bit         m_ps, m_ph, m_pm;
    bit         m_clear;
    bit         m_ingame;
    bit         m_won;
    int         m_lock;
    bit         e_inc, e_dec, e_ld;
    logic [3:0] m_score;

    score_sequencer #(
        .WIN_SCORE  (WIN_SCORE),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .hit    (hit),
        .miss   (miss),
        .score  (score),
        .Inc    (Inc),
        .Dec    (Dec),
        .LD     (LD),
        .playing(playing),
        .won    (won)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External score counter; preset lets the bench place the score directly.
    always_ff @(posedge clk) begin
        if (preset_en)  score <= preset_val;
        else if (LD)    score <= 4'd0;
        else if (Inc)   score <= score + 4'd1;
        else if (Dec)   score <= score - 4'd1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ps = 1'b1; m_ph = 1'b1; m_pm = 1'b1;
        m_clear = 1'b0; m_ingame = 1'b0; m_won = 1'b0; m_lock = 0;
        e_inc = 1'b0; e_dec = 1'b0; e_ld = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] old;
        bit s_ev, h_ev, m_ev;
        old = m_score;
        if (preset_en)  m_score = preset_val;
        else if (e_ld)  m_score = 4'd0;
        else if (e_inc) m_score = m_score + 4'd1;
        else if (e_dec) m_score = m_score - 4'd1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s_ev = start && !m_ps;
        h_ev = hit && !m_ph;
        m_ev = miss && !m_pm;
        m_ps = start; m_ph = hit; m_pm = miss;
        e_inc = 1'b0; e_dec = 1'b0; e_ld = 1'b0;
        if (s_ev) begin
            m_clear = 1'b1; m_ingame = 1'b0; m_won = 1'b0; m_lock = 0; e_ld = 1'b1;
        end else if (m_clear) begin
            m_clear = 1'b0; m_ingame = 1'b1;
        end else if (m_ingame && m_lock > 0) begin
            m_lock--;
            if (m_lock == 0 && int'(old) >= int'(WIN_SCORE)) begin
                m_ingame = 1'b0; m_won = 1'b1;
            end
        end else if (m_ingame) begin
            if (h_ev && !m_ev && old != 4'd15) begin
                e_inc = 1'b1; m_lock = HOLD_CYCLES;
            end else if (m_ev && !h_ev && old != 4'd0) begin
                e_dec = 1'b1; m_lock = HOLD_CYCLES;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_inc"}, {7'd0, Inc}, {7'd0, e_inc});
        check({tag, "_dec"}, {7'd0, Dec}, {7'd0, e_dec});
        check({tag, "_ld"}, {7'd0, LD}, {7'd0, e_ld});
        check({tag, "_playing"}, {7'd0, playing}, {7'd0, m_ingame});
        check({tag, "_won"}, {7'd0, won}, {7'd0, m_won});
        check({tag, "_score"}, {4'd0, score}, {4'd0, m_score});
        check({tag, "_onehot"}, {7'd0, $onehot0({Inc, Dec, LD})}, 8'd1);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic set_score(input logic [3:0] v);
        preset_en  = 1'b1;
        preset_val = v;
        tick("preset");
        preset_en  = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; start = 1'b1; hit = 1'b0; miss = 1'b0;
        preset_en = 1'b1; preset_val = 4'd9;
        model_reset();
        m_score = 4'd9;
        @(posedge clk);
        #1;
        preset_en = 1'b0;
        tick("reset");
        tick("reset");

        // Reset release with start already high: no event
        rst_n = 1'b1;
        tick("rel");
        tick("rel");
        check("rel_no_ld", {7'd0, LD}, 8'd0);
        start = 1'b0;
        tick("start_low");
        start = 1'b1;
        tick("start_edge");
        check("start_ld", {7'd0, LD}, 8'd1);
        tick("clear");
        check("clear_playing", {7'd0, playing}, 8'd1);
        check("clear_score", {4'd0, score}, 8'd0);

        // Hit at score 3, second hit dropped during HOLD
        set_score(4'd3);
        hit = 1'b1;
        tick("hit3");
        check("hit3_inc", {7'd0, Inc}, 8'd1);
        hit = 1'b0;
        tick("hold");
        hit = 1'b1;
        tick("hold_hit");
        check("hold_hit_inc", {7'd0, Inc}, 8'd0);
        hit = 1'b0;
        repeat (HOLD_CYCLES - 2) tick("hold");
        check("hold_end_score", {4'd0, score}, 8'd4);
        check("hold_end_playing", {7'd0, playing}, 8'd1);

        // Miss at 0 ignored; simultaneous hit+miss cancel
        set_score(4'd0);
        miss = 1'b1;
        tick("miss0");
        check("miss0_dec", {7'd0, Dec}, 8'd0);
        miss = 1'b0;
        tick("idle_play");
        hit = 1'b1; miss = 1'b1;
        tick("both");
        check("both_inc", {7'd0, Inc}, 8'd0);
        check("both_dec", {7'd0, Dec}, 8'd0);
        hit = 1'b0; miss = 1'b0;
        tick("play");

        // Winning hit from 14
        set_score(4'd14);
        hit = 1'b1;
        tick("hit14");
        check("hit14_inc", {7'd0, Inc}, 8'd1);
        hit = 1'b0;
        repeat (HOLD_CYCLES) tick("win_hold");
        check("win_won", {7'd0, won}, 8'd1);
        check("win_playing", {7'd0, playing}, 8'd0);
        hit = 1'b1;
        tick("win_hit");
        miss = 1'b1; hit = 1'b0;
        tick("win_miss");
        check("win_no_dec", {7'd0, Dec}, 8'd0);
        miss = 1'b0;
        start = 1'b0;
        tick("win_start_low");
        start = 1'b1;
        tick("win_restart");
        check("win_restart_ld", {7'd0, LD}, 8'd1);
        tick("win_clear");
        check("restart_won", {7'd0, won}, 8'd0);
        check("restart_playing", {7'd0, playing}, 8'd1);

        // Start and hit together: LD only
        set_score(4'd5);
        start = 1'b0;
        tick("pre_start");
        start = 1'b1; hit = 1'b1;
        tick("start_hit");
        check("start_hit_ld", {7'd0, LD}, 8'd1);
        check("start_hit_inc", {7'd0, Inc}, 8'd0);
        hit = 1'b0;
        tick("clear2");
        hit = 1'b1;
        tick("hit_hold");
        hit = 1'b0;
        repeat (3) tick("mid_hold");
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_playing", {7'd0, playing}, 8'd0);
        check_all("async_rst");
        tick("rst_hold");
        rst_n = 1'b1;
        tick("rst_rel");

        // Random play
        for (int i = 0; i < 3000; i++) begin
            rst_n = 1'b1;
            if ($urandom_range(0, 99) < 3) start = ~start;
            if ($urandom_range(0, 3) == 0) hit = ~hit;
            if ($urandom_range(0, 4) == 0) miss = ~miss;
            preset_en = ($urandom_range(0, 59) == 0);
            preset_val = ($urandom_range(0, 1) == 0) ? 4'(13 + $urandom_range(0, 2))
                                                       : 4'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rnd_rst");
            end
            tick("rnd");
        end
        preset_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
